// File: rtl/awb_div_pkg.sv
// awb_div_pkg: shared widths, saturation value and in-flight tag type for the divider scheduler
package awb_div_pkg;
    localparam int DIVIDEND_W = 24;
    localparam int DIVISOR_W = 16;
    localparam int QUOT_W = 24;
    localparam logic [QUOT_W-1:0] QUOT_SAT = 24'hFFFFFF;
    typedef struct packed {
        logic       valid;
        logic [2:0] id;
        logic       div0;
    } tag_t;
endpackage

// File: rtl/awb_div_rr_arbiter.sv
// awb_div_rr_arbiter: N-way round-robin arbiter, one-hot grant plus index, pointer advances past each grant
module awb_div_rr_arbiter #(
    parameter int N = 3,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant,
    output logic [W-1:0] grant_idx,
    output logic         grant_valid
);
    logic [W-1:0] rr_ptr;
    logic [W-1:0] cand;
    // Scan from the farthest offset down so the nearest eligible index at/after rr_ptr wins
    always_comb begin
        grant_idx = '0;
        grant_valid = 1'b0;
        cand = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = W'((int'(rr_ptr) + k) % N);
            if (req[cand]) begin
                grant_idx = cand;
                grant_valid = 1'b1;
            end
        end
        grant = grant_valid ? (N'(1) << grant_idx) : '0;
    end
    always_ff @(posedge clk) begin
        if (reset)
            rr_ptr <= '0;
        else if (grant_valid)
            rr_ptr <= (grant_idx == W'(N - 1)) ? '0 : grant_idx + W'(1);
    end
endmodule

// File: rtl/awb_div_scheduler.sv
// awb_div_scheduler: shares one fixed-latency pipelined divider among N_REQ requesters,
// tracking each issue with a tag pipe and routing the quotient back to its owner
module awb_div_scheduler
    import awb_div_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int DIV_LATENCY = 30
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_REQ-1:0]            req_valid,
    output logic [N_REQ-1:0]            req_ready,
    input  logic [N_REQ*DIVIDEND_W-1:0] req_dividend,
    input  logic [N_REQ*DIVISOR_W-1:0]  req_divisor,
    output logic [N_REQ-1:0]            rsp_valid,
    output logic [QUOT_W-1:0]           rsp_quotient,
    output logic                        rsp_div0,
    output logic [DIVIDEND_W-1:0]       div_dividend,
    output logic [DIVISOR_W-1:0]        div_divisor,
    input  logic [QUOT_W-1:0]           div_quotient,
    output logic                        busy
);
    localparam int IW = $clog2(N_REQ);
    logic [N_REQ-1:0] pending;
    logic [N_REQ-1:0] grant;
    logic [IW-1:0] grant_idx;
    logic grant_valid;
    logic [DIVIDEND_W-1:0] sel_dividend;
    logic [DIVISOR_W-1:0] sel_divisor;
    logic sel_div0;
    logic [N_REQ-1:0] retire_mask;
    tag_t tags [DIV_LATENCY+1];
    tag_t tag_end;

    awb_div_rr_arbiter #(.N(N_REQ)) u_arb (
        .clk        (clk),
        .reset      (reset),
        .req        (req_valid & ~pending & {N_REQ{~reset}}),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .grant_valid(grant_valid)
    );

    assign req_ready = grant;
    assign busy = |pending;
    assign sel_dividend = req_dividend[int'(grant_idx)*DIVIDEND_W +: DIVIDEND_W];
    assign sel_divisor = req_divisor[int'(grant_idx)*DIVISOR_W +: DIVISOR_W];
    assign sel_div0 = grant_valid && sel_divisor == '0;
    assign tag_end = tags[DIV_LATENCY];
    assign retire_mask = tag_end.valid ? (N_REQ'(1) << tag_end.id) : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
            rsp_valid <= '0;
            rsp_quotient <= '0;
            rsp_div0 <= 1'b0;
            div_dividend <= '0;
            div_divisor <= DIVISOR_W'(1);
            for (int i = 0; i <= DIV_LATENCY; i++)
                tags[i] <= '0;
        end else begin
            div_dividend <= grant_valid ? sel_dividend : '0;
            // A zero divisor never reaches the divider; the tag carries the fault instead
            div_divisor <= (grant_valid && !sel_div0) ? sel_divisor : DIVISOR_W'(1);
            tags[0] <= '{valid: grant_valid, id: 3'(grant_idx), div0: sel_div0};
            for (int i = 1; i <= DIV_LATENCY; i++)
                tags[i] <= tags[i-1];
            rsp_valid <= retire_mask;
            if (tag_end.valid) begin
                rsp_quotient <= tag_end.div0 ? QUOT_SAT : div_quotient;
                rsp_div0 <= tag_end.div0;
            end
            pending <= (pending | grant) & ~retire_mask;
        end
    end
endmodule

// File: tb/tb_awb_div_scheduler.sv
// tb_awb_div_scheduler: table-driven and sequence checks with a response scoreboard and a behavioural divider
module tb_awb_div_scheduler;
    localparam int N = 3;
    localparam int L = 30;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [N-1:0] req_valid = '0;
    logic [N-1:0] req_ready;
    logic [N*24-1:0] req_dividend = '0;
    logic [N*16-1:0] req_divisor = '0;
    logic [N-1:0] rsp_valid;
    logic [23:0] rsp_quotient;
    logic rsp_div0;
    logic [23:0] div_dividend;
    logic [15:0] div_divisor;
    logic [23:0] div_quotient;
    logic busy;

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;

    awb_div_scheduler #(.N_REQ(N), .DIV_LATENCY(L)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_dividend(req_dividend), .req_divisor(req_divisor), .rsp_valid(rsp_valid),
        .rsp_quotient(rsp_quotient), .rsp_div0(rsp_div0), .div_dividend(div_dividend),
        .div_divisor(div_divisor), .div_quotient(div_quotient), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Divider model: quotient of the inputs seen in cycle c appears in cycle c+L
    logic [23:0] qp [L];
    initial for (int k = 0; k < L; k++) qp[k] = '0;
    always @(posedge clk) begin
        qp[0] <= (div_divisor == 0) ? 24'hFFFFFF : div_dividend / 24'(div_divisor);
        for (int k = 1; k < L; k++) qp[k] <= qp[k-1];
    end
    assign div_quotient = qp[L-1];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    endtask

    typedef struct {int id; logic [23:0] q; logic d0; int t;} exp_t;
    exp_t sb[$];

    always @(negedge clk) begin : mon
        exp_t e;
        logic [23:0] dvd;
        logic [15:0] dvs;
        if (reset) sb.delete();
        else begin
            if (rsp_valid != 0) begin
                if (sb.size() == 0) chk("rsp_unexpected", 32'(rsp_valid), 0);
                else begin
                    e = sb.pop_front();
                    chk("sb_rsp_id", 32'(rsp_valid), 32'(1) << e.id);
                    chk("sb_rsp_quotient", 32'(rsp_quotient), 32'(e.q));
                    chk("sb_rsp_div0", 32'(rsp_div0), 32'(e.d0));
                    chk("sb_latency", 32'(cyc - e.t), L + 2);
                end
            end
            for (int i = 0; i < N; i++)
                if (req_valid[i] && req_ready[i]) begin
                    dvd = req_dividend[i*24 +: 24];
                    dvs = req_divisor[i*16 +: 16];
                    e.id = i;
                    e.d0 = (dvs == 0);
                    e.q = e.d0 ? 24'hFFFFFF : dvd / 24'(dvs);
                    e.t = cyc;
                    sb.push_back(e);
                end
        end
    end

    task automatic set_req(input int id, input logic [23:0] dvd, input logic [15:0] dvs);
        req_dividend[id*24 +: 24] = dvd;
        req_divisor[id*16 +: 16] = dvs;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(n < 200), 1);
    endtask

    task automatic run_one(input int id, input logic [23:0] dvd, input logic [15:0] dvs,
                           input logic [23:0] q, input logic d0);
        int n = 0;
        @(posedge clk) #1;
        set_req(id, dvd, dvs);
        req_valid[id] = 1'b1;
        @(negedge clk);
        chk("ready", 32'(req_ready), 32'(1) << id);
        @(posedge clk) #1;
        req_valid[id] = 1'b0;
        @(negedge clk);
        chk("div_dividend", 32'(div_dividend), 32'(dvd));
        chk("div_divisor", 32'(div_divisor), (dvs == 0) ? 1 : 32'(dvs));
        while (rsp_valid == 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_seen", 32'(rsp_valid != 0), 1);
        chk("rsp_quotient", 32'(rsp_quotient), 32'(q));
        chk("rsp_div0", 32'(rsp_div0), 32'(d0));
        drain();
    endtask

    typedef struct {int id; logic [23:0] dvd; logic [15:0] dvs; logic [23:0] q; logic d0;} vec_t;
    vec_t vt[5];

    initial begin
        int at[$];
        int g[$];
        int c0, c1, pulses;
        vt[0] = '{0, 24'h010000, 16'h0080, 24'h000200, 1'b0};
        vt[1] = '{1, 24'h123400, 16'h0000, 24'hFFFFFF, 1'b1};
        vt[2] = '{0, 24'h000007, 16'h0002, 24'h000003, 1'b0};
        vt[3] = '{1, 24'h000000, 16'h0005, 24'h000000, 1'b0};
        vt[4] = '{2, 24'hFFFFFF, 16'hFFFF, 24'h000100, 1'b0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_quotient", 32'(rsp_quotient), 0);
        chk("rst_div0", 32'(rsp_div0), 0);
        chk("rst_div_dividend", 32'(div_dividend), 0);
        chk("rst_div_divisor", 32'(div_divisor), 1);
        chk("rst_busy", 32'(busy), 0);
        @(posedge clk) #1;
        reset = 1'b0;

        foreach (vt[i]) run_one(vt[i].id, vt[i].dvd, vt[i].dvs, vt[i].q, vt[i].d0);

        // Simultaneous requests: rr_ptr is back at 0 after the last grant to 2
        @(posedge clk) #1;
        for (int i = 0; i < N; i++) set_req(i, 24'h000400, 16'(1 << i));
        req_valid = '1;
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            chk("simul_grant", 32'(req_ready), 32'(1) << k);
            @(posedge clk) #1;
            req_valid[k] = 1'b0;
        end
        @(negedge clk);
        chk("simul_busy", 32'(busy), 1);
        drain();

        // Held valid: re-accept exactly when the response arrives
        @(posedge clk) #1;
        set_req(0, 24'h000900, 16'h0003);
        req_valid[0] = 1'b1;
        repeat (3 * (L + 2) + 1) begin
            @(negedge clk);
            if (req_ready[0]) at.push_back(cyc);
        end
        @(posedge clk) #1;
        req_valid[0] = 1'b0;
        chk("held_accepts", 32'(at.size()), 4);
        if (at.size() >= 3) begin
            chk("held_period0", 32'(at[1] - at[0]), L + 2);
            chk("held_period1", 32'(at[2] - at[1]), L + 2);
        end
        drain();

        // Fairness: rr_ptr is 1 after the last grant to 0
        @(posedge clk) #1;
        set_req(0, 24'h000050, 16'h0005);
        set_req(1, 24'h000051, 16'h0003);
        req_valid = 3'b011;
        repeat (2 * (L + 2) + 2) begin
            @(negedge clk);
            if (req_ready[0]) g.push_back(0);
            if (req_ready[1]) g.push_back(1);
        end
        @(posedge clk) #1;
        req_valid = '0;
        c0 = 0;
        c1 = 0;
        foreach (g[i]) if (g[i] == 0) c0++; else c1++;
        chk("fair_grants", 32'(g.size()), 6);
        if (g.size() >= 2) begin
            chk("fair_first", 32'(g[0]), 1);
            chk("fair_second", 32'(g[1]), 0);
        end
        chk("fair_cnt0", 32'(c0), 3);
        chk("fair_cnt1", 32'(c1), 3);
        drain();

        // Reset mid-operation discards in-flight results
        @(posedge clk) #1;
        set_req(0, 24'h000100, 16'h0002);
        set_req(1, 24'h000100, 16'h0004);
        req_valid = 3'b011;
        repeat (2) @(posedge clk);
        #1;
        req_valid = '0;
        @(negedge clk);
        chk("rstmid_busy", 32'(busy), 1);
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk) #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rstmid_busy_clr", 32'(busy), 0);
        chk("rstmid_rsp_valid", 32'(rsp_valid), 0);
        chk("rstmid_quotient", 32'(rsp_quotient), 0);
        chk("rstmid_div_divisor", 32'(div_divisor), 1);
        pulses = 0;
        repeat (L + 10) begin
            @(negedge clk);
            if (rsp_valid != 0) pulses++;
        end
        chk("rstmid_no_rsp", 32'(pulses), 0);
        run_one(2, 24'h000064, 16'h000A, 24'h00000A, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/awb_div_scheduler.md
# awb_div_scheduler

Shares one pipelined integer divider (24-bit dividend / 16-bit divisor → 24-bit quotient, fixed latency) between up to N_REQ requesters in the ISP statistics/gain path, e.g. the AWB R-gain and B-gain computations and the AE ratio. It arbitrates requests round-robin and drives the divider inputs. It tracks every in-flight operation with a tag pipeline and returns each quotient to the requester that issued it. Divide-by-zero is caught before issue.

## Interface
- N_REQ, 3: number of requesters (2..8)
- DIV_LATENCY, 30: cycles from divider input change to matching `div_quotient`
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  N_REQ  request present, per requester
- req_ready  out  N_REQ  request accepted this cycle
- req_dividend  in  N_REQ*24  packed, requester i at [24i+23:24i]
- req_divisor  in  N_REQ*16  packed, requester i at [16i+15:16i]
- rsp_valid  out  N_REQ  one-cycle result strobe
- rsp_quotient  out  24  quotient, qualified by any `rsp_valid` bit
- rsp_div0  out  1  result was a divide-by-zero, qualified by `rsp_valid`
- div_dividend  out  24  to divider
- div_divisor  out  16  to divider
- div_quotient  in  24  from divider
- busy  out  1  any operation in flight

## Operation
- Clock and reset are fixed: one clock `clk`; `reset` is synchronous and active-high.
- **Outstanding limit:** each requester may have at most one operation in flight. `pending[i]` sets on accept and clears on its response.
- **Arbitration:** the eligible set is `req_valid[i] & ~pending[i]`.
  - Grant the lowest eligible index at or above `rr_ptr`, wrapping around.
  - At most one grant per cycle.
  - `req_ready[i]` is the combinational grant. It may depend on `req_valid`.
  - On accept, `rr_ptr` moves to (grant+1) mod N_REQ. With no accept, `rr_ptr` holds.
- **Requester rule:** a requester holds valid and data stable until ready.
- **Issue:**
  - On accept, register the dividend into `div_dividend`.
  - Register the divisor into `div_divisor`, substituting 16'd1 when it is 0.
  - Push tag {valid=1, id, div0} into a DIV_LATENCY+1 deep shift register.
- **Idle issue:** in cycles with no accept, `div_dividend`=0 and `div_divisor`=1, and a tag with valid=0 is pushed.
- **Retire:** when the tag at the pipe end is valid:
  - `rsp_valid[id]`=1 for one cycle.
  - `rsp_quotient` = div0 ? 24'hFFFFFF : `div_quotient`, registered.
  - `rsp_div0` = div0.
  - `pending[id]` clears in the same edge as the response registers.
- **Grant during retire:** requester id becomes eligible in the cycle `rsp_valid[id]` is high. It is not eligible earlier.
- **busy** = any `pending` bit set.
- **Reset values:**
  - `req_ready`=0, `rsp_valid`=0, `rsp_quotient`=0, `rsp_div0`=0.
  - `div_dividend`=0, `div_divisor`=1.
  - `busy`=0, `rr_ptr`=0, all tags invalid, `pending`=0.
- **Reset mid-operation:** the tag pipe clears, so in-flight results are discarded and no `rsp_valid` is produced for them. The divider itself is not reset by this block; its stale quotients are ignored because their tags are gone.

## Timing
- Cycle t: `req_valid[i]&&req_ready[i]`.
- t+1: divider inputs presented.
- t+1+DIV_LATENCY: `div_quotient` valid.
- t+2+DIV_LATENCY: `rsp_valid[i]` and `rsp_quotient` valid, for exactly one cycle.
- Total latency is DIV_LATENCY+2 and constant, independent of contention.
- Throughput is one issue per cycle across requesters. Responses come back in issue order, with at most one per cycle.
- Earliest re-accept for the same requester is cycle t+2+DIV_LATENCY.
- The first accept is possible in the first cycle after `reset` deasserts.

## Structure
- Package `awb_div_pkg` holds:
  - DIVIDEND_W=24, DIVISOR_W=16, QUOT_W=24.
  - QUOT_SAT=24'hFFFFFF.
  - The tag struct type {valid, id[2:0], div0}.
- Sub-module `awb_div_rr_arbiter` (N-way round-robin, grant one-hot plus index, pointer update on accept).
- The tag shift register and pending flags live in the top module. The divider is instantiated outside this block.

## Test plan
- **Single request:** req 0, dividend 0x010000, divisor 0x0080 → `div_divisor`=0x0080 one cycle later; `rsp_valid`=3'b001 exactly DIV_LATENCY+2 cycles after accept, `rsp_quotient`=0x000200, `rsp_div0`=0.
- **Simultaneous requests:** all 3 valid in the same cycle (divisors 1, 2, 4, dividend 0x000400) → grants 0, 1, 2 on consecutive cycles; quotients 0x400, 0x200, 0x100 on consecutive cycles with matching `rsp_valid` bits.
- **Held valid:** req 0 held valid continuously → `req_ready[0]` low while pending; re-accepted in the cycle its `rsp_valid` pulses (period DIV_LATENCY+2).
- **Fairness:** req 0 and req 1 both always valid, with `rr_ptr` at 1 → first grant 1, then 0; grants never starve either requester.
- **Divide-by-zero:** divisor 0, dividend 0x123400 → `div_divisor`=1, `rsp_quotient`=0xFFFFFF, `rsp_div0`=1.
- **Reset mid-operation:** `reset` pulsed 10 cycles after issuing 2 ops → no `rsp_valid` ever appears for them; outputs at reset values, `busy`=0; a new request after reset completes normally.
